// File: rtl/flt_pkg.sv
// Shared definitions for the half-precision to int16 converter.
// The state list includes ROUND, which is only reachable when FLT2INT_ROUND_EN is defined.
package flt_pkg;

    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;
    localparam int BIAS   = 15;

    localparam logic [15:0] INT_MAX = 16'h7FFF;
    localparam logic [15:0] INT_MIN = 16'h8000;

    // At e = BIAS+MANT_W the hidden-one mantissa is already an integer; at e = BIAS+15 it no longer fits int16.
    localparam logic [EXP_W-1:0] EXP_LSH  = 5'(BIAS + MANT_W);
    localparam logic [EXP_W-1:0] EXP_SAT  = 5'(BIAS + 15);
    localparam logic [EXP_W-1:0] EXP_HALF = 5'(BIAS - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RD_LO  = 4'd1,
        S_RD_HI  = 4'd2,
        S_DECODE = 4'd3,
        S_SHIFT  = 4'd4,
        S_ROUND  = 4'd5,
        S_NEGATE = 4'd6,
        S_WR_LO  = 4'd7,
        S_WR_HI  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    function automatic logic rne_up(input logic lsb, input logic rnd, input logic sticky);
        return rnd & (sticky | lsb);
    endfunction

endpackage

// File: rtl/flt_grs_shifter.sv
// Iterative shifter that moves the magnitude by one bit per cycle.
// On right shifts, the bits shifted out feed round and sticky.
module flt_grs_shifter
    import flt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_dir,
    input  logic [4:0]  i_count,
    input  logic [15:0] i_mag,
    output logic        o_done,
    output logic [15:0] o_mag,
    output logic        o_guard,
    output logic        o_round,
    output logic        o_sticky
);

    logic [15:0] r_mag;
    logic [4:0]  r_count;
    logic        r_dir;
    logic        r_round;
    logic        r_sticky;

    // Load a new operand, then shift once per cycle until the count runs out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag    <= 16'd0;
            r_count  <= 5'd0;
            r_dir    <= 1'b0;
            r_round  <= 1'b0;
            r_sticky <= 1'b0;
        end else if (i_load) begin
            r_mag    <= i_mag;
            r_count  <= i_count;
            r_dir    <= i_dir;
            r_round  <= 1'b0;
            r_sticky <= 1'b0;
        end else if (r_count != 5'd0) begin
            r_count <= r_count - 5'd1;
            if (r_dir) begin
                r_mag <= {r_mag[14:0], 1'b0};
            end else begin
                r_mag    <= {1'b0, r_mag[15:1]};
                r_round  <= r_mag[0];
                r_sticky <= r_sticky | r_round;
            end
        end
    end

    // o_done marks the cycle in which the last shift happens.
    assign o_done   = (r_count <= 5'd1);
    assign o_mag    = r_mag;
    assign o_guard  = r_mag[0];
    assign o_round  = r_round;
    assign o_sticky = r_sticky;

endmodule

// File: rtl/flt2int_conv.sv
// Half-precision float to int16 converter sharing data_mem and the start/done handshake with the float adder.
// Define FLT2INT_ROUND_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module flt2int_conv
    import flt_pkg::*;
#(
    parameter logic [7:0] SRC_LO = 8'd4,
    parameter logic [7:0] SRC_HI = 8'd5,
    parameter logic [7:0] DST_LO = 8'd6,
    parameter logic [7:0] DST_HI = 8'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    output logic       o_done,
    output logic [7:0] o_mem_addr,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic [7:0] o_mem_wdata,
    input  logic [7:0] i_mem_rdata
);

`ifdef FLT2INT_ROUND_EN
    localparam state_t AFTER_SHIFT = S_ROUND;
`else
    localparam state_t AFTER_SHIFT = S_NEGATE;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [15:0] r_result;
    logic [15:0] w_next_result;
    logic        r_done;
    logic [7:0]  r_mem_addr;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [7:0]  r_mem_wdata;
    logic [7:0]  w_addr_d;
    logic        w_rd_d;
    logic        w_wr_d;
    logic [7:0]  w_wdata_d;
    logic        w_done_d;

    logic              w_sign;
    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_mant;
    logic [15:0]       w_mag;
    logic              w_is_zero;
    logic              w_is_sat;
    logic              w_left;
    logic [4:0]        w_ldist;
    logic [4:0]        w_rdist;
    logic [4:0]        w_k;
    logic              w_load;
    logic [15:0]       w_neg_src;

    logic        w_sh_done;
    logic [15:0] w_sh_mag;
    logic        w_sh_guard;
    logic        w_sh_round;
    logic        w_sh_sticky;

    assign w_sign    = r_hi[7];
    assign w_exp     = r_hi[6:2];
    assign w_mant    = {r_hi[1:0], r_lo};
    assign w_mag     = {5'd0, 1'b1, w_mant};
    assign w_is_zero = (w_exp == 5'd0);
    assign w_is_sat  = (w_exp >= EXP_SAT);
    assign w_left    = (w_exp >= EXP_LSH);
    assign w_ldist   = w_exp - EXP_LSH;
    assign w_rdist   = EXP_LSH - w_exp;
    // Eleven right shifts already empty the 11-bit magnitude, so longer distances are clamped.
    assign w_k       = w_left ? w_ldist : ((w_rdist > 5'd11) ? 5'd11 : w_rdist);

    flt_grs_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_dir    (w_left),
        .i_count  ((w_is_zero || w_is_sat) ? 5'd0 : w_k),
        .i_mag    (w_is_zero ? 16'd0 : w_mag),
        .o_done   (w_sh_done),
        .o_mag    (w_sh_mag),
        .o_guard  (w_sh_guard),
        .o_round  (w_sh_round),
        .o_sticky (w_sh_sticky)
    );

`ifdef FLT2INT_ROUND_EN
    logic        r_tiny;
    logic        w_rnd_up;
    logic [16:0] w_rnd_sum;
    logic [15:0] w_rnd_lim;
    logic [15:0] w_rnd_mag;

    // Values below one half never round up, even though the clamped shift leaves bit 10 in round.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tiny <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_tiny <= (w_exp < EXP_HALF);
        end
    end

    assign w_rnd_up  = !r_tiny && rne_up(w_sh_guard, w_sh_round, w_sh_sticky);
    assign w_rnd_sum = {1'b0, w_sh_mag} + {16'd0, w_rnd_up};
    assign w_rnd_lim = w_sign ? INT_MIN : INT_MAX;
    assign w_rnd_mag = (w_rnd_sum > {1'b0, w_rnd_lim}) ? w_rnd_lim : w_rnd_sum[15:0];
    assign w_neg_src = r_result;
`else
    logic [2:0] w_unused_grs;
    assign w_unused_grs = {w_sh_guard, w_sh_round, w_sh_sticky};
    assign w_neg_src    = w_sh_mag;
`endif

    // Next-state and next-result logic.
    always_comb begin
        w_next_state  = r_state;
        w_next_result = r_result;
        w_load        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_next_state = S_RD_LO;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_RD_LO: w_next_state = S_RD_HI;
            S_RD_HI: w_next_state = S_DECODE;
            S_DECODE: begin
                w_load = 1'b1;
                if (w_is_zero) begin
                    w_next_result = 16'd0;
                    w_next_state  = S_NEGATE;
                end else if (w_is_sat) begin
                    w_next_result = w_sign ? INT_MIN : INT_MAX;
                    w_next_state  = S_WR_LO;
                end else if (w_k != 5'd0) begin
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = AFTER_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_sh_done) begin
                    w_next_state = AFTER_SHIFT;
                end else begin
                    w_next_state = S_SHIFT;
                end
            end
`ifdef FLT2INT_ROUND_EN
            S_ROUND: begin
                w_next_result = w_rnd_mag;
                w_next_state  = S_NEGATE;
            end
`endif
            S_NEGATE: begin
                w_next_result = w_sign ? (~w_neg_src + 16'd1) : w_neg_src;
                w_next_state  = S_WR_LO;
            end
            S_WR_LO: w_next_state = S_WR_HI;
            S_WR_HI: w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they register in step with the state.
    always_comb begin
        w_addr_d  = 8'd0;
        w_rd_d    = 1'b0;
        w_wr_d    = 1'b0;
        w_wdata_d = 8'd0;
        w_done_d  = 1'b0;
        case (w_next_state)
            S_RD_LO: begin
                w_rd_d   = 1'b1;
                w_addr_d = SRC_LO;
            end
            S_RD_HI: begin
                w_rd_d   = 1'b1;
                w_addr_d = SRC_HI;
            end
            S_WR_LO: begin
                w_wr_d    = 1'b1;
                w_addr_d  = DST_LO;
                w_wdata_d = w_next_result[7:0];
            end
            S_WR_HI: begin
                w_wr_d    = 1'b1;
                w_addr_d  = DST_HI;
                w_wdata_d = w_next_result[15:8];
            end
            S_DONE:  w_done_d = 1'b1;
            default: w_done_d = 1'b0;
        endcase
    end

    // State, operand bytes, result and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lo        <= 8'd0;
            r_hi        <= 8'd0;
            r_result    <= 16'd0;
            r_done      <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_result    <= w_next_result;
            r_done      <= w_done_d;
            r_mem_addr  <= w_addr_d;
            r_mem_rd    <= w_rd_d;
            r_mem_wr    <= w_wr_d;
            r_mem_wdata <= w_wdata_d;
            if (r_state == S_RD_LO) begin
                r_lo <= i_mem_rdata;
            end
            if (r_state == S_RD_HI) begin
                r_hi <= i_mem_rdata;
            end
        end
    end

    assign o_done      = r_done;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
